ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus operand-forwarding front end for the 16-bit RISC core.
- Captures decoded fields and register-file read data each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and WB stages.
- Detects load-use hazards and inserts a bubble.
- Drives the ALU's src1/src2/alu_control inputs and carries destination info downstream.

Parameters:
DATA_W, 16, datapath width
REG_ADDR_W, 3, register address width (8 GPRs, no hardwired zero)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1_addr  in  REG_ADDR_W  source 1 index
id_rs2_addr  in  REG_ADDR_W  source 2 index
id_rs1_data  in  DATA_W  register-file read data, source 1
id_rs2_data  in  DATA_W  register-file read data, source 2
id_imm  in  DATA_W  sign/zero-extended immediate
id_use_imm  in  1  src2 = immediate (rs2 not used)
id_alu_control  in  3  ALU function select
id_rd_addr  in  REG_ADDR_W  destination index
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
stall_in  in  1  downstream hold request
flush  in  1  branch/jump squash of this stage's next contents
exm_reg_write  in  1  EX/MEM stage writes a register
exm_rd_addr  in  REG_ADDR_W  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
wb_reg_write  in  1  WB stage writes a register
wb_rd_addr  in  REG_ADDR_W  WB destination
wb_data  in  DATA_W  WB write data
alu_src1  out  DATA_W  ALU operand 1 (forwarded)
alu_src2  out  DATA_W  ALU operand 2 (forwarded or immediate)
alu_control  out  3  registered function select
ex_valid  out  1  this stage holds a valid instruction
ex_rd_addr  out  REG_ADDR_W  registered destination
ex_reg_write  out  1  registered write enable (0 when invalid)
ex_mem_read  out  1  registered load flag (0 when invalid)
ex_store_data  out  DATA_W  forwarded rs2 value, for stores
hazard_stall  out  1  decode/fetch must hold this cycle

Behaviour:
- Reset: all registers 0. ex_valid=0, ex_reg_write=0, ex_mem_read=0, alu_control=3'b000, ex_rd_addr=0. Operand outputs are 0 while no forwarding matches.
- hazard_stall (combinational) = ex_valid & ex_mem_read & id_valid & ((ex_rd_addr==id_rs1_addr) | (!id_use_imm & ex_rd_addr==id_rs2_addr)). Forced to 0 when flush=1.
- Update priority per rising edge: flush > stall_in > hazard_stall > normal load.
  - flush: ex_valid, ex_reg_write, ex_mem_read <= 0. Data fields don't care.
  - stall_in: every register holds, including ex_valid.
  - hazard_stall: bubble inserted, with ex_valid, ex_reg_write, ex_mem_read <= 0. Decode holds, so the same instruction is re-captured next cycle.
  - normal: capture all id_* fields. ex_reg_write <= id_reg_write & id_valid; ex_mem_read <= id_mem_read & id_valid.
- Capture-time bypass: if wb_reg_write and wb_rd_addr==id_rsN_addr, the stored rsN value is wb_data, not id_rsN_data. This covers a register-file write in the same cycle as the read.
- Forwarding (combinational, on registered rs addresses), per operand N:
  - exm_result if exm_reg_write & exm_rd_addr==ex_rsN_addr;
  - else wb_data if wb_reg_write & wb_rd_addr==ex_rsN_addr;
  - else the stored value.
  - EX/MEM has priority over WB.
- alu_src2 = stored immediate when use_imm, else forwarded rs2. ex_store_data is always forwarded rs2.
- Latency: 1 cycle from id_* capture to ALU operands. Forwarding adds no cycles.
- Forwarded and stored values are passed bit-exact with no width conversion.
- Mid-operation async reset returns the stage to the reset state immediately; the in-flight instruction is discarded.

Decomposition:
- Shared package risc_pkg holds:
  - DATA_W, REG_ADDR_W;
  - ALU op constants: ALU_ADD=000, ALU_SUB=001, ALU_INV=010, ALU_SHL=011, ALU_SHR=100, ALU_AND=101, ALU_OR=110, ALU_SLT=111.
- One sub-module, forward_mux: 3-way priority select with address compares, instantiated twice (rs1, rs2).

Test Plan:
- Reset then no stimulus -> ex_valid=0, ex_reg_write=0, alu_control=000, hazard_stall=0.
- Back-to-back dependency:
  - stimulus: ADD r1 (exm_result=0x0005), then SUB reads r1, stored id_rs1_data=0x0000;
  - response: alu_src1=0x0005.
- Forward priority:
  - stimulus: exm writes r2=0x1111 and wb writes r2=0x2222 simultaneously, instruction reads r2;
  - response: alu_src1=0x1111.
- Load-use:
  - stimulus: load r3 in stage (ex_mem_read=1), id reads r3;
  - response: hazard_stall=1 for one cycle, bubble (ex_valid=0), then instruction captured with ex_valid=1.
- Immediate path: use_imm=1, imm=0x00FF, rs2 matches exm_rd -> alu_src2=0x00FF, ex_store_data=exm_result.
- Simultaneous stall_in=1 and flush=1 -> flush wins, ex_valid=0 next cycle. Then stall_in=1 alone -> all outputs held unchanged for the whole stall.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: datapath widths and ALU opcodes.
package risc_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_INV = 3'b010,
        ALU_SHL = 3'b011,
        ALU_SHR = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // True when a later pipeline stage is writing the register being read.
    function automatic logic writes_reg(input logic we, input reg_addr_t rd, input reg_addr_t rs);
        return we && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between decode/forwarding sources and the EX operand stage.
interface ex_operand_stage_if;
    import risc_pkg::*;

    // Decode-side instruction fields
    logic      id_valid;
    reg_addr_t id_rs1_addr;
    reg_addr_t id_rs2_addr;
    data_t     id_rs1_data;
    data_t     id_rs2_data;
    data_t     id_imm;
    logic      id_use_imm;
    logic [2:0] id_alu_control;
    reg_addr_t id_rd_addr;
    logic      id_reg_write;
    logic      id_mem_read;

    // Pipeline control
    logic      stall_in;
    logic      flush;

    // Forwarding sources
    logic      exm_reg_write;
    reg_addr_t exm_rd_addr;
    data_t     exm_result;
    logic      wb_reg_write;
    reg_addr_t wb_rd_addr;
    data_t     wb_data;

    // Stage outputs
    data_t     alu_src1;
    data_t     alu_src2;
    logic [2:0] alu_control;
    logic      ex_valid;
    reg_addr_t ex_rd_addr;
    logic      ex_reg_write;
    logic      ex_mem_read;
    data_t     ex_store_data;
    logic      hazard_stall;

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_control, id_rd_addr, id_reg_write,
               id_mem_read, stall_in, flush, exm_reg_write, exm_rd_addr,
               exm_result, wb_reg_write, wb_rd_addr, wb_data,
        output alu_src1, alu_src2, alu_control, ex_valid, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_store_data, hazard_stall
    );

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_control, id_rd_addr, id_reg_write,
               id_mem_read, stall_in, flush, exm_reg_write, exm_rd_addr,
               exm_result, wb_reg_write, wb_rd_addr, wb_data,
        input  alu_src1, alu_src2, alu_control, ex_valid, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_store_data, hazard_stall
    );

endinterface

// File: rtl/ex_operand_stage_forward_mux.sv
// Three-way operand select: EX/MEM result, then WB data, then the stored value.
module forward_mux
    import risc_pkg::*;
(
    input  reg_addr_t rs_addr,
    input  data_t     stored,
    input  logic      exm_reg_write,
    input  reg_addr_t exm_rd_addr,
    input  data_t     exm_result,
    input  logic      wb_reg_write,
    input  reg_addr_t wb_rd_addr,
    input  data_t     wb_data,
    output data_t     operand
);

    // EX/MEM is the younger producer, so it overrides WB on the same register.
    always_comb begin
        operand = stored;
        if (writes_reg(exm_reg_write, exm_rd_addr, rs_addr)) begin
            operand = exm_result;
        end else if (writes_reg(wb_reg_write, wb_rd_addr, rs_addr)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and load-use bubble insertion.
module ex_operand_stage
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ex_operand_stage_if.slave  bus
);

    logic       ex_valid_q,     ex_valid_d;
    logic       ex_reg_write_q, ex_reg_write_d;
    logic       ex_mem_read_q,  ex_mem_read_d;
    logic [2:0] alu_control_q,  alu_control_d;
    reg_addr_t  ex_rd_addr_q,   ex_rd_addr_d;
    reg_addr_t  ex_rs1_addr_q,  ex_rs1_addr_d;
    reg_addr_t  ex_rs2_addr_q,  ex_rs2_addr_d;
    data_t      rs1_data_q,     rs1_data_d;
    data_t      rs2_data_q,     rs2_data_d;
    data_t      imm_q,          imm_d;
    logic       use_imm_q,      use_imm_d;

    logic       hazard_stall;
    data_t      fwd_rs1;
    data_t      fwd_rs2;

    // Load in EX whose destination feeds the decoding instruction; squashed instructions never stall.
    always_comb begin
        hazard_stall = 1'b0;
        if (!bus.flush && ex_valid_q && ex_mem_read_q && bus.id_valid) begin
            hazard_stall = (ex_rd_addr_q == bus.id_rs1_addr) ||
                           (!bus.id_use_imm && (ex_rd_addr_q == bus.id_rs2_addr));
        end
    end

    // Next-state selection: flush > stall_in > load-use bubble > normal capture.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        alu_control_d  = alu_control_q;
        ex_rd_addr_d   = ex_rd_addr_q;
        ex_rs1_addr_d  = ex_rs1_addr_q;
        ex_rs2_addr_d  = ex_rs2_addr_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        imm_d          = imm_q;
        use_imm_d      = use_imm_q;
        if (bus.flush || (!bus.stall_in && hazard_stall)) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (!bus.stall_in) begin
            ex_valid_d     = bus.id_valid;
            ex_reg_write_d = bus.id_reg_write & bus.id_valid;
            ex_mem_read_d  = bus.id_mem_read & bus.id_valid;
            alu_control_d  = bus.id_alu_control;
            ex_rd_addr_d   = bus.id_rd_addr;
            ex_rs1_addr_d  = bus.id_rs1_addr;
            ex_rs2_addr_d  = bus.id_rs2_addr;
            imm_d          = bus.id_imm;
            use_imm_d      = bus.id_use_imm;
            // A WB write to the register being read this cycle is not yet visible in the register file.
            rs1_data_d     = writes_reg(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs1_addr)
                             ? bus.wb_data : bus.id_rs1_data;
            rs2_data_d     = writes_reg(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs2_addr)
                             ? bus.wb_data : bus.id_rs2_data;
        end
    end

    // Stage register; async reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            alu_control_q  <= ALU_ADD;
            ex_rd_addr_q   <= '0;
            ex_rs1_addr_q  <= '0;
            ex_rs2_addr_q  <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            use_imm_q      <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            alu_control_q  <= alu_control_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_rs1_addr_q  <= ex_rs1_addr_d;
            ex_rs2_addr_q  <= ex_rs2_addr_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            use_imm_q      <= use_imm_d;
        end
    end

    forward_mux u_fwd_rs1 (
        .rs_addr       (ex_rs1_addr_q),
        .stored        (rs1_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd_addr   (bus.exm_rd_addr),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_data       (bus.wb_data),
        .operand       (fwd_rs1)
    );

    forward_mux u_fwd_rs2 (
        .rs_addr       (ex_rs2_addr_q),
        .stored        (rs2_data_q),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd_addr   (bus.exm_rd_addr),
        .exm_result    (bus.exm_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_data       (bus.wb_data),
        .operand       (fwd_rs2)
    );

    assign bus.alu_src1      = fwd_rs1;
    assign bus.alu_src2      = use_imm_q ? imm_q : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.alu_control   = alu_control_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_rd_addr    = ex_rd_addr_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.hazard_stall  = hazard_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with a queue of expected values.
module tb_ex_operand_stage;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ex_operand_stage_if bus();

    ex_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   passes = 0;
    int   total  = 0;

    task automatic push_exp(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_out(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h required=an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) passes++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic drive_id(input logic v, input reg_addr_t rs1, input data_t d1,
                            input reg_addr_t rs2, input data_t d2, input data_t imm,
                            input logic use_imm, input logic [2:0] alu, input reg_addr_t rd,
                            input logic rw, input logic mr);
        bus.id_valid       = v;
        bus.id_rs1_addr    = rs1;
        bus.id_rs1_data    = d1;
        bus.id_rs2_addr    = rs2;
        bus.id_rs2_data    = d2;
        bus.id_imm         = imm;
        bus.id_use_imm     = use_imm;
        bus.id_alu_control = alu;
        bus.id_rd_addr     = rd;
        bus.id_reg_write   = rw;
        bus.id_mem_read    = mr;
    endtask

    task automatic fwd(input logic ew, input reg_addr_t erd, input data_t eres,
                       input logic ww, input reg_addr_t wrd, input data_t wd);
        bus.exm_reg_write = ew;
        bus.exm_rd_addr   = erd;
        bus.exm_result    = eres;
        bus.wb_reg_write  = ww;
        bus.wb_rd_addr    = wrd;
        bus.wb_data       = wd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=no finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive_id(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 0, 0, 0);
        fwd(0, 0, 16'h0, 0, 0, 16'h0);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Reset state
        push_exp("rst_valid", 16'h0);       check_out(16'(bus.ex_valid));
        push_exp("rst_reg_write", 16'h0);   check_out(16'(bus.ex_reg_write));
        push_exp("rst_mem_read", 16'h0);    check_out(16'(bus.ex_mem_read));
        push_exp("rst_alu_ctrl", 16'h0);    check_out(16'(bus.alu_control));
        push_exp("rst_hazard", 16'h0);      check_out(16'(bus.hazard_stall));
        push_exp("rst_src1", 16'h0);        check_out(bus.alu_src1);

        // Back-to-back dependency: SUB reads r1 produced by ADD now in EX/MEM
        drive_id(1, 1, 16'h0000, 4, 16'h0044, 16'h0, 0, ALU_SUB, 5, 1, 0);
        push_exp("b2b_src1", 16'h0005);
        push_exp("b2b_src2", 16'h0044);
        push_exp("b2b_ctrl", 16'h0001);
        push_exp("b2b_valid", 16'h0001);
        push_exp("b2b_rd", 16'h0005);
        push_exp("b2b_reg_write", 16'h0001);
        cyc();
        drive_id(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 0, 0, 0);
        fwd(1, 1, 16'h0005, 0, 0, 16'h0);
        #1;
        check_out(bus.alu_src1);
        check_out(bus.alu_src2);
        check_out(16'(bus.alu_control));
        check_out(16'(bus.ex_valid));
        check_out(16'(bus.ex_rd_addr));
        check_out(16'(bus.ex_reg_write));
        fwd(0, 0, 16'h0, 0, 0, 16'h0);

        // Forward priority: EX/MEM over WB, then WB, then stored value
        drive_id(1, 2, 16'h0ABC, 2, 16'h0BCD, 16'h7777, 1, ALU_OR, 2, 1, 0);
        push_exp("prio_src1", 16'h1111);
        push_exp("prio_src2_imm", 16'h7777);
        push_exp("prio_store", 16'h1111);
        push_exp("wb_src1", 16'h2222);
        push_exp("stored_src1", 16'h0ABC);
        push_exp("stored_store", 16'h0BCD);
        cyc();
        drive_id(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 0, 0, 0);
        fwd(1, 2, 16'h1111, 1, 2, 16'h2222);
        #1;
        check_out(bus.alu_src1);
        check_out(bus.alu_src2);
        check_out(bus.ex_store_data);
        fwd(0, 0, 16'h0, 1, 2, 16'h2222);
        #1 check_out(bus.alu_src1);
        fwd(0, 0, 16'h0, 0, 0, 16'h0);
        #1 check_out(bus.alu_src1);
        check_out(bus.ex_store_data);

        // Capture-time bypass from a same-cycle register-file write
        drive_id(1, 6, 16'h1234, 0, 16'h0, 16'h0, 0, ALU_ADD, 1, 1, 0);
        fwd(0, 0, 16'h0, 1, 6, 16'hBEEF);
        push_exp("bypass_src1", 16'hBEEF);
        cyc();
        fwd(0, 0, 16'h0, 0, 0, 16'h0);
        #1 check_out(bus.alu_src1);

        // Load-use: load r3, then an instruction reading r3
        drive_id(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 3, 1, 1);
        push_exp("lu_mem_read", 16'h1);
        cyc();
        check_out(16'(bus.ex_mem_read));
        drive_id(1, 3, 16'h0033, 5, 16'h0055, 16'h0, 0, ALU_ADD, 7, 1, 0);
        push_exp("lu_hazard", 16'h1);
        push_exp("lu_bubble_valid", 16'h0);
        push_exp("lu_bubble_reg_write", 16'h0);
        push_exp("lu_hazard_cleared", 16'h0);
        push_exp("lu_valid", 16'h1);
        push_exp("lu_rd", 16'h0007);
        push_exp("lu_src1", 16'h0033);
        #1 check_out(16'(bus.hazard_stall));
        cyc();
        check_out(16'(bus.ex_valid));
        check_out(16'(bus.ex_reg_write));
        check_out(16'(bus.hazard_stall));
        cyc();
        check_out(16'(bus.ex_valid));
        check_out(16'(bus.ex_rd_addr));
        check_out(bus.alu_src1);

        // Hazard boundaries: immediate hides rs2, rs2 match stalls, flush masks
        drive_id(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 3, 1, 1);
        cyc();
        drive_id(1, 1, 16'h0, 3, 16'h0, 16'h0001, 1, ALU_ADD, 2, 1, 0);
        push_exp("lu_imm_no_stall", 16'h0);
        #1 check_out(16'(bus.hazard_stall));
        drive_id(1, 1, 16'h0, 3, 16'h0, 16'h0001, 0, ALU_ADD, 2, 1, 0);
        push_exp("lu_rs2_stall", 16'h1);
        #1 check_out(16'(bus.hazard_stall));
        bus.flush = 1'b1;
        push_exp("lu_flush_mask", 16'h0);
        push_exp("flush_valid", 16'h0);
        #1 check_out(16'(bus.hazard_stall));
        cyc();
        check_out(16'(bus.ex_valid));
        bus.flush = 1'b0;

        // Immediate path with rs2 forwarded to store data
        drive_id(1, 0, 16'h0, 4, 16'h0000, 16'h00FF, 1, ALU_ADD, 1, 1, 0);
        push_exp("imm_src2", 16'h00FF);
        push_exp("imm_store", 16'h4242);
        cyc();
        fwd(1, 4, 16'h4242, 0, 0, 16'h0);
        #1;
        check_out(bus.alu_src2);
        check_out(bus.ex_store_data);
        fwd(0, 0, 16'h0, 0, 0, 16'h0);

        // flush beats stall_in
        drive_id(1, 1, 16'h0, 0, 16'h0, 16'h0, 0, ALU_OR, 2, 1, 0);
        push_exp("pre_flush_valid", 16'h1);
        cyc();
        check_out(16'(bus.ex_valid));
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        drive_id(1, 3, 16'h0, 0, 16'h0, 16'h0, 0, ALU_SHL, 4, 1, 0);
        push_exp("sf_valid", 16'h0);
        push_exp("sf_reg_write", 16'h0);
        cyc();
        check_out(16'(bus.ex_valid));
        check_out(16'(bus.ex_reg_write));
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;

        // stall_in alone holds everything
        drive_id(1, 1, 16'h5555, 2, 16'h6666, 16'h0, 0, ALU_AND, 6, 1, 0);
        cyc();
        bus.stall_in = 1'b1;
        drive_id(1, 7, 16'h9999, 3, 16'h8888, 16'h0, 0, ALU_SLT, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push_exp("stall_valid", 16'h1);
            push_exp("stall_ctrl", 16'h0005);
            push_exp("stall_rd", 16'h0006);
            push_exp("stall_src1", 16'h5555);
            push_exp("stall_src2", 16'h6666);
            cyc();
            check_out(16'(bus.ex_valid));
            check_out(16'(bus.alu_control));
            check_out(16'(bus.ex_rd_addr));
            check_out(bus.alu_src1);
            check_out(bus.alu_src2);
        end
        bus.stall_in = 1'b0;
        push_exp("release_ctrl", 16'h0007);
        push_exp("release_rd", 16'h0004);
        push_exp("release_reg_write", 16'h0);
        cyc();
        check_out(16'(bus.alu_control));
        check_out(16'(bus.ex_rd_addr));
        check_out(16'(bus.ex_reg_write));

        // Asynchronous reset mid-cycle discards the instruction in flight
        drive_id(1, 2, 16'h1357, 0, 16'h0, 16'h0, 0, ALU_SHR, 5, 1, 1);
        push_exp("ar_pre_valid", 16'h1);
        push_exp("ar_valid", 16'h0);
        push_exp("ar_ctrl", 16'h0);
        push_exp("ar_mem_read", 16'h0);
        cyc();
        check_out(16'(bus.ex_valid));
        #2 rst_n = 1'b0;
        #1;
        check_out(16'(bus.ex_valid));
        check_out(16'(bus.alu_control));
        check_out(16'(bus.ex_mem_read));
        drive_id(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, ALU_ADD, 0, 0, 0);
        rst_n = 1'b1;
        cyc();

        if (sb.size() != 0) begin
            total++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
